oam_dma_engine: RTL and testbench

Standalone sprite-DMA controller on the CPU bus, upstream of the PPU's OAM write port. It replaces the inline OAM DMA counter in the top-level architecture. On a CPU write to $4014 it halts the CPU and copies the 256-byte page $XX00–$XXFF into OAM as alternating bus-read/OAM-write cycles. It reproduces the 2A03's 513/514-cycle stall, including get/put parity alignment.

---
 rtl/oam_dma_engine_pkg.sv | 6 +
 rtl/oam_dma_engine_if.sv | 23 ++
 rtl/oam_dma_engine.sv | 86 ++++++++
 tb/tb_oam_dma_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_engine_pkg.sv
// nes_pkg: shared NES types and constants used by the OAM DMA engine.
package nes_pkg;
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
    localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
    localparam int OAM_BYTES = 256;
endpackage

// File: rtl/oam_dma_engine_if.sv
// oam_dma_engine_if: CPU-side trigger inputs, bus read data and OAM write port of the sprite DMA.
interface oam_dma_engine_if;
    logic        ENABLE;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_OUT;
    logic        CPU_RW_n;
    logic [7:0]  BUS_DATA_IN;
    logic        DMA_ACTIVE;
    logic [15:0] DMA_ADDR;
    logic        DMA_RD;
    logic        DMA_WRITE;
    logic [7:0]  DMA_OAM_ADDR;
    logic [7:0]  DMA_DATA;
    logic        DMA_DONE;
    modport master (
        input  ENABLE, CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, BUS_DATA_IN,
        output DMA_ACTIVE, DMA_ADDR, DMA_RD, DMA_WRITE, DMA_OAM_ADDR, DMA_DATA, DMA_DONE
    );
    modport slave (
        output ENABLE, CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, BUS_DATA_IN,
        input  DMA_ACTIVE, DMA_ADDR, DMA_RD, DMA_WRITE, DMA_OAM_ADDR, DMA_DATA, DMA_DONE
    );
endinterface

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: 2A03-style sprite DMA that halts the CPU and copies one page into OAM.
// Define OAM_DMA_ALIGN_EN to add the get/put parity ALIGN cycle (513/514-cycle stall).
module oam_dma_engine
    import nes_pkg::*;
#(
    parameter logic [15:0] OAM_DMA_REG = OAM_DMA_REG_ADDR,
    parameter int          PAGE_BYTES  = OAM_BYTES
) (
    input logic              CLK,
    input logic              RESET_n,
    oam_dma_engine_if.master bus
);
    localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);
    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d, index_q, index_d, data_q, data_d;
    logic       done_q, done_d;
`ifdef OAM_DMA_ALIGN_EN
    logic       parity_q, parity_d;
`endif
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            page_q   <= '0;
            index_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            data_q   <= data_d;
            done_q   <= done_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= parity_d;
`endif
        end
    end
    // DONE is cleared on the next CLK regardless of ENABLE so the pulse is exactly one CLK wide.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        data_d   = data_q;
        done_d   = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        parity_d = parity_q ^ bus.ENABLE;
`endif
        if (bus.ENABLE) begin
            case (state_q)
                IDLE: if (!bus.CPU_RW_n && bus.CPU_ADDR == OAM_DMA_REG) begin
                    page_d  = bus.CPU_DATA_OUT;
                    index_d = '0;
                    state_d = HALT;
                end
`ifdef OAM_DMA_ALIGN_EN
                HALT:    state_d = parity_q ? ALIGN : READ;
                ALIGN:   state_d = READ;
`else
                HALT:    state_d = READ;
`endif
                READ: begin
                    data_d  = bus.BUS_DATA_IN;
                    state_d = WRITE;
                end
                WRITE: if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = READ;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    assign bus.DMA_ACTIVE   = state_q != IDLE;
    assign bus.DMA_RD       = state_q == READ;
    assign bus.DMA_WRITE    = state_q == WRITE;
    assign bus.DMA_ADDR     = bus.DMA_RD ? {page_q, index_q} : 16'h0000;
    assign bus.DMA_OAM_ADDR = index_q;
    assign bus.DMA_DATA     = data_q;
    assign bus.DMA_DONE     = done_q;
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: table-driven trigger decode plus randomized transfers checked against a page-copy model.
module tb_oam_dma_engine;
    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    oam_dma_engine_if bus();
    oam_dma_engine dut (.CLK(CLK), .RESET_n(RESET_n), .bus(bus));
    always #5 CLK = ~CLK;
`ifdef OAM_DMA_ALIGN_EN
    localparam int ALIGN = 1;
`else
    localparam int ALIGN = 0;
`endif
    typedef struct {
        logic        en;
        logic        rw_n;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_act;
    } vec_t;
    vec_t vecs[7];
    int total = 0;
    int bad = 0;
    int en_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Bus RAM model: page $02 holds i^$5A; other pages are made distinct by their page number.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    task automatic tick(input logic en);
        bus.ENABLE = en;
        bus.BUS_DATA_IN = mem(bus.DMA_ADDR);
        @(posedge CLK);
        #1;
        if (en && RESET_n) en_cnt++;
    endtask

    task automatic idle_inputs();
        bus.CPU_RW_n = 1'b1;
        bus.CPU_ADDR = 16'h0000;
        bus.CPU_DATA_OUT = 8'h00;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " active"}, bus.DMA_ACTIVE, 0);
        check({tag, " rd"}, bus.DMA_RD, 0);
        check({tag, " wr"}, bus.DMA_WRITE, 0);
        check({tag, " addr"}, bus.DMA_ADDR, 0);
        check({tag, " oam_addr"}, bus.DMA_OAM_ADDR, 0);
        check({tag, " data"}, bus.DMA_DATA, 0);
        check({tag, " done"}, bus.DMA_DONE, 0);
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        en_cnt = 0;
        idle_inputs();
        @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    task automatic pad_to_parity(input int halt_par);
        while ((en_cnt + 1) % 2 != halt_par) tick(1'b1);
    endtask

    task automatic run_dma(input string tag, input logic [7:0] page, input int en_pct, input bit glitch);
        int stall = 0, nwr = 0, order_err = 0, data_err = 0, addr_err = 0, overlap = 0;
        int dones = 0, done_err = 0, first_rd = -1, clks = 0, exp_stall;
        logic [15:0] last_rd = 16'h0000;
        logic [7:0] exp_idx = 8'h00;
        logic en, prev_act;
        bus.CPU_RW_n = 1'b0;
        bus.CPU_ADDR = 16'h4014;
        bus.CPU_DATA_OUT = page;
        tick(1'b1);
        idle_inputs();
        exp_stall = 513 + ((ALIGN != 0) ? en_cnt % 2 : 0);
        check({tag, " rise"}, bus.DMA_ACTIVE, 1);
        do begin
            en = $urandom_range(0, 99) < en_pct;
            if (glitch && $urandom_range(0, 7) == 0) begin
                bus.CPU_RW_n = 1'b0;
                bus.CPU_ADDR = 16'h4014;
                bus.CPU_DATA_OUT = 8'($urandom);
            end else idle_inputs();
            if (bus.DMA_RD && bus.DMA_WRITE) overlap++;
            if (en && bus.DMA_ACTIVE) begin
                stall++;
                if (bus.DMA_RD) begin
                    if (first_rd < 0) first_rd = stall - 1;
                    last_rd = bus.DMA_ADDR;
                    if (bus.DMA_ADDR !== {page, exp_idx}) addr_err++;
                end
                if (bus.DMA_WRITE) begin
                    if (bus.DMA_OAM_ADDR !== exp_idx) order_err++;
                    if (bus.DMA_DATA !== mem({page, exp_idx})) data_err++;
                    nwr++;
                    exp_idx++;
                end
            end
            prev_act = bus.DMA_ACTIVE;
            tick(en);
            clks++;
            if (bus.DMA_DONE) begin
                dones++;
                if (!(prev_act && !bus.DMA_ACTIVE)) done_err++;
            end
        end while (bus.DMA_ACTIVE && clks < 5000);
        idle_inputs();
        check({tag, " timeout"}, clks < 5000, 1);
        check({tag, " stall"}, stall, exp_stall);
        check({tag, " first_rd"}, first_rd, exp_stall - 512);
        check({tag, " writes"}, nwr, 256);
        check({tag, " order_err"}, order_err, 0);
        check({tag, " data_err"}, data_err, 0);
        check({tag, " addr_err"}, addr_err, 0);
        check({tag, " overlap"}, overlap, 0);
        check({tag, " last_rd"}, last_rd, {page, 8'hFF});
        check({tag, " dones"}, dones, 1);
        check({tag, " done_pos"}, done_err, 0);
        tick(1'($urandom_range(0, 1)));
        check({tag, " done_width"}, bus.DMA_DONE, 0);
        check({tag, " idle_after"}, bus.DMA_ACTIVE, 0);
    endtask

    initial begin
        int act_seen, found, dones;
        vecs[0] = '{1'b1, 1'b0, 16'h4014, 8'h02, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 16'h4014, 8'h02, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h4014, 8'h02, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h4015, 8'h02, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h4004, 8'h02, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'hC014, 8'h02, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h4014, 8'hFF, 1'b1};
        bus.ENABLE = 1'b0;
        bus.BUS_DATA_IN = 8'h00;
        idle_inputs();
        #1;
        check_zero("reset");
        do_reset();
        act_seen = 0;
        for (int i = 0; i < 100; i++) begin
            bus.CPU_RW_n = 1'b1;
            bus.CPU_ADDR = 16'h4014;
            tick(1'b1);
            if (bus.DMA_ACTIVE) act_seen++;
        end
        idle_inputs();
        check("idle active", act_seen, 0);
        check_zero("idle");

        foreach (vecs[i]) begin
            do_reset();
            bus.CPU_RW_n = vecs[i].rw_n;
            bus.CPU_ADDR = vecs[i].addr;
            bus.CPU_DATA_OUT = vecs[i].data;
            tick(vecs[i].en);
            idle_inputs();
            check($sformatf("vec%0d active", i), bus.DMA_ACTIVE, vecs[i].exp_act);
            check($sformatf("vec%0d rd", i), bus.DMA_RD, 0);
        end

        do_reset();
        pad_to_parity(0);
        run_dma("even", 8'h02, 100, 0);
        pad_to_parity(1);
        run_dma("odd", 8'h02, 100, 0);
        pad_to_parity(0);
        run_dma("pageff", 8'hFF, 100, 0);
        run_dma("toggle", 8'h02, 50, 0);

        found = 0;
        bus.CPU_RW_n = 1'b0;
        bus.CPU_ADDR = 16'h4014;
        bus.CPU_DATA_OUT = 8'h02;
        tick(1'b1);
        idle_inputs();
        for (int i = 0; i < 2000 && found == 0; i++) begin
            if (bus.DMA_WRITE && bus.DMA_OAM_ADDR == 8'h40) found = 1;
            else tick(1'($urandom_range(0, 1)));
        end
        check("abort reach", found, 1);
        RESET_n = 1'b0;
        en_cnt = 0;
        #1;
        check_zero("abort");
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            if (bus.DMA_DONE) dones++;
        end
        @(negedge CLK);
        RESET_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            if (bus.DMA_DONE || bus.DMA_ACTIVE) dones++;
        end
        check("abort no_done", dones, 0);
        run_dma("restart", 8'h02, 100, 0);

        for (int r = 0; r < 4; r++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick(1'b1);
            run_dma($sformatf("rnd%0d", r), 8'($urandom), 60, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
